// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared widths and the buffered write-port entry type for the
//               writeback port arbiter and its result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int REG_WIDTH = 32;
    localparam int REG_COUNT = 32;
    localparam int REG_BITS  = $clog2(REG_COUNT);

    // One pending register-file write from the long-latency unit.
    typedef struct packed {
        logic [REG_BITS-1:0]  dst;
        logic [REG_WIDTH-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO of wb_entry_t. Besides head/full/empty it
//               exposes the slot valid vector and destinations as they will
//               be after the current edge, so the owner can register a
//               per-register pending mask in step with the contents.
// Ports       : clk, rst (async, active high), push/push_entry, pop,
//               full, empty, head, valid_next[DEPTH], dst_next[DEPTH]
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  wb_entry_t                        push_entry,
    input  logic                             pop,
    output logic                             full,
    output logic                             empty,
    output wb_entry_t                        head,
    output logic [DEPTH-1:0]                 valid_next,
    output logic [DEPTH-1:0][REG_BITS-1:0]   dst_next
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_W-1:0]     offset;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        offset     = '0;
        valid_next = '0;
        dst_next   = '0;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        // A slot is live when its distance from the new read pointer is
        // below the new occupancy (pointers wrap modulo DEPTH).
        for (int i = 0; i < DEPTH; i++) begin
            offset        = ADDR_W'(i) - rd_ptr_d;
            valid_next[i] = ({1'b0, offset} < count_d);
            dst_next[i]   = mem_d[i].dst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between the in-order
//               writeback stage (fixed priority) and the long-latency unit,
//               whose results are buffered and drained into idle cycles.
//               A starvation guard asks the hazard unit for a bubble when the
//               buffer head has been blocked for STARVE_LIMIT cycles.
// Ports       : clk, rst (async, active high)
//               pipe_we/pipe_reg/pipe_data  - writeback stage request
//               lu_valid/lu_reg/lu_data     - long-unit result, lu_ready back
//               rf_we/rf_reg/rf_data        - register-file write port
//               pending_mask                - registers with buffered writes
//               stall_req                   - writeback bubble request
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int REG_WIDTH    = wb_pkg::REG_WIDTH,
    parameter int REG_COUNT    = wb_pkg::REG_COUNT,
    parameter int REG_BITS     = $clog2(REG_COUNT),
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_we,
    input  logic [REG_BITS-1:0]  pipe_reg,
    input  logic [REG_WIDTH-1:0] pipe_data,
    input  logic                 lu_valid,
    input  logic [REG_BITS-1:0]  lu_reg,
    input  logic [REG_WIDTH-1:0] lu_data,
    output logic                 lu_ready,
    output logic                 rf_we,
    output logic [REG_BITS-1:0]  rf_reg,
    output logic [REG_WIDTH-1:0] rf_data,
    output logic [REG_COUNT-1:0] pending_mask,
    output logic                 stall_req
);
    import wb_pkg::wb_entry_t;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } starve_state_t;

    logic                                pipe_active;
    logic                                do_push;
    logic                                do_pop;
    logic                                fifo_full;
    logic                                fifo_empty;
    wb_entry_t                           fifo_head;
    wb_entry_t                           lu_entry;
    logic [FIFO_DEPTH-1:0]               valid_next;
    logic [FIFO_DEPTH-1:0][REG_BITS-1:0] dst_next;

    starve_state_t        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 stall_req_q, stall_req_d;
    logic [REG_COUNT-1:0] pending_mask_q, pending_mask_d;

    // Writes to x0 are idle cycles and never win the port.
    assign pipe_active = pipe_we && (pipe_reg != '0);
    assign do_pop      = !pipe_active && !fifo_empty;

    // Readiness is purely !full; a same-cycle pop does not open a slot.
    // Accepted x0 results are dropped instead of buffered.
    assign lu_ready    = !fifo_full;
    assign do_push     = lu_valid && !fifo_full && (lu_reg != '0);
    assign lu_entry    = '{dst: lu_reg, data: lu_data};

    assign rf_we   = !rst && (pipe_active || !fifo_empty);
    assign rf_reg  = pipe_active ? pipe_reg  : fifo_head.dst;
    assign rf_data = pipe_active ? pipe_data : fifo_head.data;

    assign pending_mask = pending_mask_q;
    assign stall_req    = stall_req_q;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (do_push),
        .push_entry (lu_entry),
        .pop        (do_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head),
        .valid_next (valid_next),
        .dst_next   (dst_next)
    );

    // Mask reflects the contents after this edge, so a bit drops on the
    // same edge that pops the last entry for that register.
    always_comb begin
        pending_mask_d = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (valid_next[i]) begin
                pending_mask_d[dst_next[i]] = 1'b1;
            end
        end
    end

    // Starvation guard: count cycles the head is blocked by the pipeline.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_req_d = 1'b0;
        if (fifo_empty) begin
            cnt_d   = '0;
            state_d = do_push ? ST_WAIT : ST_IDLE;
        end else if (do_pop) begin
            cnt_d   = '0;
            state_d = (valid_next == '0) ? ST_IDLE : ST_WAIT;
        end else begin
            if (cnt_q != CNT_W'(STARVE_LIMIT)) begin
                cnt_d = cnt_q + 1'b1;
            end
            state_d = ((state_q == ST_STALL) || (cnt_d == CNT_W'(STARVE_LIMIT)))
                      ? ST_STALL : ST_WAIT;
        end
        stall_req_d = (state_d == ST_STALL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            stall_req_q    <= 1'b0;
            pending_mask_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_req_q    <= stall_req_d;
            pending_mask_q <= pending_mask_d;
        end
    end

endmodule
`default_nettype wire
